path_stack: RTL and testbench

- Direction stack for the maze-solver datapath.
- Stores the 2-bit move codes the solver controller pushes while advancing, and returns the top code on pop for backtracking.
- After the controller reports success, replays the stored path bottom-to-top as a move stream for the output/display stage, then signals all_read.
- Sits directly downstream of the solver controller: consumes push/wr/pop/read/clear and produces poped, is_empty_st and all_read.

---
 rtl/path_stack.sv | 153 +++++++++++++++
 tb/tb_path_stack.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/path_stack.sv
// path_stack: direction stack for the maze-solver datapath.
//   Stores 2-bit move codes pushed by the solver controller, returns the top
//   code on pop for backtracking, and after success replays the stored path
//   bottom-to-top as a move stream, then raises all_read.
// Ports:
//   clk, rst (async, active-low)
//   clear                 synchronous empty, clears error flags
//   push, wr, din[1:0]    push din (push and wr both required)
//   pop                   pop top entry into poped (registered)
//   read                  replay request level, held until all_read
//   poped[1:0]            last popped code
//   is_empty_st, full     combinational from stack pointer
//   ovf_err, unf_err      sticky push-while-full / pop-while-empty
//   move_out[1:0], move_valid, all_read   replay stream and completion
module path_stack #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       push,
   input  logic       wr,
   input  logic [1:0] din,
   input  logic       pop,
   input  logic       read,
   output logic [1:0] poped,
   output logic       is_empty_st,
   output logic       full,
   output logic       ovf_err,
   output logic       unf_err,
   output logic [1:0] move_out,
   output logic       move_valid,
   output logic       all_read
);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

   state_t        state, state_nxt;
   logic [AW:0]   sp;
   logic [AW:0]   rd_ptr;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] top_idx;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic          op_en;
   logic          push_wr;
   logic          rd_more;

   always_comb begin
      is_empty_st = (sp == '0);
      full        = (sp == SP_FULL);
      top_idx     = sp[AW-1:0] - AW'(1);
      push_wr     = push & wr;
      // Starting a replay takes the edge; stack ops wait so the replay
      // sees a stable snapshot.
      op_en       = (state == IDLE) && !read && !clear;
      rd_more     = (rd_ptr < sp);
      wr_en       = 1'b0;
      wr_addr     = sp[AW-1:0];
      if (op_en && push_wr) begin
         if (pop && !is_empty_st) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
         end else if (!full) begin
            wr_en   = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (read) state_nxt = is_empty_st ? DONE : READ;
         READ:    if (!rd_more) state_nxt = DONE;
         DONE:    if (!read) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp         <= '0;
         rd_ptr     <= '0;
         poped      <= '0;
         move_out   <= '0;
         move_valid <= 1'b0;
         all_read   <= 1'b0;
         ovf_err    <= 1'b0;
         unf_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (read) begin
                  if (is_empty_st) begin
                     all_read <= 1'b1;
                  end else begin
                     move_out   <= mem[0];
                     move_valid <= 1'b1;
                     rd_ptr     <= SP_ONE;
                  end
               end else if (clear) begin
                  sp      <= '0;
                  ovf_err <= 1'b0;
                  unf_err <= 1'b0;
               end else if (push_wr && pop && !is_empty_st) begin
                  // Swap: old top goes out, din replaces it, sp unchanged.
                  poped <= mem[top_idx];
               end else if (push_wr) begin
                  if (full) ovf_err <= 1'b1;
                  else      sp      <= sp + SP_ONE;
               end else if (pop) begin
                  if (is_empty_st) begin
                     unf_err <= 1'b1;
                  end else begin
                     poped <= mem[top_idx];
                     sp    <= sp - SP_ONE;
                  end
               end
            end
            READ: begin
               if (rd_more) begin
                  move_out <= mem[rd_ptr[AW-1:0]];
                  rd_ptr   <= rd_ptr + SP_ONE;
               end else begin
                  move_valid <= 1'b0;
                  all_read   <= 1'b1;
               end
            end
            DONE: begin
               if (!read) begin
                  all_read <= 1'b0;
                  rd_ptr   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_path_stack.sv
module tb_path_stack;

   logic       clk = 1'b0;
   logic       rst, clear, push, wr, pop, read;
   logic [1:0] din;
   logic [1:0] poped, move_out;
   logic       is_empty_st, full, ovf_err, unf_err, move_valid, all_read;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   path_stack #(.DEPTH(256), .AW(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .push(push), .wr(wr), .din(din),
      .pop(pop), .read(read), .poped(poped), .is_empty_st(is_empty_st),
      .full(full), .ovf_err(ovf_err), .unf_err(unf_err),
      .move_out(move_out), .move_valid(move_valid), .all_read(all_read)
   );

   typedef struct {
      logic       clr, psh, w;
      logic [1:0] d;
      logic       pp, rd;
      logic [1:0] e_poped;
      logic       e_empty, e_ovf, e_unf, e_mv;
      logic [1:0] e_mo;
      logic       e_ar;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic clr_i, logic psh_i, logic w_i, logic [1:0] d_i,
                               logic pp_i, logic rd_i, logic [1:0] ep, logic ee,
                               logic eo, logic eu, logic emv, logic [1:0] emo, logic ear);
      vec_t v;
      v.clr = clr_i; v.psh = psh_i; v.w = w_i; v.d = d_i; v.pp = pp_i; v.rd = rd_i;
      v.e_poped = ep; v.e_empty = ee; v.e_ovf = eo; v.e_unf = eu;
      v.e_mv = emv; v.e_mo = emo; v.e_ar = ear;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic p, input logic w, input logic [1:0] d,
                        input logic pp, input logic r);
      @(negedge clk);
      clear = c; push = p; wr = w; din = d; pop = pp; read = r;
      @(posedge clk);
      #1;
   endtask

   // packed view: poped, empty, full, ovf, unf, mv, move_out(when valid), all_read
   function automatic logic [15:0] pack_out(logic [1:0] p, logic e, logic f, logic o,
                                            logic u, logic mv, logic [1:0] mo, logic ar);
      return {6'b0, p, e, f, o, u, mv, mo, ar};
   endfunction

   initial begin
      rst = 1'b0; clear = 0; push = 0; wr = 0; din = 2'b00; pop = 0; read = 0;

      // table: clr psh w din pop read | poped empty ovf unf mv mo ar
      vq.push_back(mk(0,1,1,2'b01,0,0, 2'b00,0,0,0,0,2'b00,0)); // 0 push 01
      vq.push_back(mk(0,1,1,2'b01,0,0, 2'b00,0,0,0,0,2'b00,0)); // 1 push 01
      vq.push_back(mk(0,1,1,2'b11,0,0, 2'b00,0,0,0,0,2'b00,0)); // 2 push 11
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b11,0,0,0,0,2'b00,0)); // 3 pop -> 11
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b01,0,0,0,0,2'b00,0)); // 4 pop -> 01
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b01,1,0,0,0,2'b00,0)); // 5 pop -> empty
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b01,1,0,1,0,2'b00,0)); // 6 underflow
      vq.push_back(mk(1,0,0,2'b00,1,0, 2'b01,1,0,0,0,2'b00,0)); // 7 clear wins
      vq.push_back(mk(0,1,0,2'b11,0,0, 2'b01,1,0,0,0,2'b00,0)); // 8 push w/o wr
      vq.push_back(mk(0,1,1,2'b01,0,0, 2'b01,0,0,0,0,2'b00,0)); // 9 push 01
      vq.push_back(mk(0,1,1,2'b10,1,0, 2'b01,0,0,0,0,2'b00,0)); // 10 swap
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b10,1,0,0,0,2'b00,0)); // 11 pop -> 10
      vq.push_back(mk(0,1,1,2'b10,1,0, 2'b10,0,0,0,0,2'b00,0)); // 12 push+pop empty
      vq.push_back(mk(1,1,1,2'b01,0,0, 2'b10,1,0,0,0,2'b00,0)); // 13 clear+push
      vq.push_back(mk(0,0,0,2'b00,0,1, 2'b10,1,0,0,0,2'b00,1)); // 14 read empty
      vq.push_back(mk(0,0,0,2'b00,0,1, 2'b10,1,0,0,0,2'b00,1)); // 15 held
      vq.push_back(mk(0,0,0,2'b00,0,0, 2'b10,1,0,0,0,2'b00,0)); // 16 drop read
      vq.push_back(mk(0,1,1,2'b00,0,0, 2'b10,0,0,0,0,2'b00,0)); // 17 push 00
      vq.push_back(mk(0,1,1,2'b01,0,0, 2'b10,0,0,0,0,2'b00,0)); // 18 push 01
      vq.push_back(mk(0,1,1,2'b10,0,0, 2'b10,0,0,0,0,2'b00,0)); // 19 push 10
      vq.push_back(mk(0,0,0,2'b00,0,1, 2'b10,0,0,0,1,2'b00,0)); // 20 replay 00
      vq.push_back(mk(0,0,0,2'b00,0,1, 2'b10,0,0,0,1,2'b01,0)); // 21 replay 01
      vq.push_back(mk(0,1,1,2'b11,0,1, 2'b10,0,0,0,1,2'b10,0)); // 22 replay 10, push ignored
      vq.push_back(mk(0,0,0,2'b00,1,1, 2'b10,0,0,0,0,2'b00,1)); // 23 done, pop ignored
      vq.push_back(mk(1,0,0,2'b00,0,1, 2'b10,0,0,0,0,2'b00,1)); // 24 clear ignored
      vq.push_back(mk(0,0,0,2'b00,0,0, 2'b10,0,0,0,0,2'b00,0)); // 25 drop read
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b10,0,0,0,0,2'b00,0)); // 26 pop -> 10
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b01,0,0,0,0,2'b00,0)); // 27 pop -> 01
      vq.push_back(mk(0,0,0,2'b00,1,0, 2'b00,1,0,0,0,2'b00,0)); // 28 pop -> 00
      vq.push_back(mk(0,1,1,2'b11,0,0, 2'b00,0,0,0,0,2'b00,0)); // 29 push 11
      vq.push_back(mk(0,1,1,2'b00,0,0, 2'b00,0,0,0,0,2'b00,0)); // 30 push 00
      vq.push_back(mk(0,0,0,2'b00,0,1, 2'b00,0,0,0,1,2'b11,0)); // 31 replay 11
      vq.push_back(mk(0,0,0,2'b00,0,0, 2'b00,0,0,0,1,2'b00,0)); // 32 read dropped, continues
      vq.push_back(mk(0,0,0,2'b00,0,0, 2'b00,0,0,0,0,2'b00,1)); // 33 all_read pulse
      vq.push_back(mk(0,0,0,2'b00,0,0, 2'b00,0,0,0,0,2'b00,0)); // 34 back to idle
      vq.push_back(mk(1,0,0,2'b00,0,0, 2'b00,1,0,0,0,2'b00,0)); // 35 clear

      #12;
      chk("reset", pack_out(poped, is_empty_st, full, ovf_err, unf_err, move_valid, move_out, all_read),
          pack_out(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      @(negedge clk);
      rst = 1'b1;

      foreach (vq[i]) begin
         vec_t v;
         v = vq[i];
         drive(v.clr, v.psh, v.w, v.d, v.pp, v.rd);
         chk($sformatf("vec%0d", i),
             pack_out(poped, is_empty_st, full, ovf_err, unf_err, move_valid,
                      v.e_mv ? move_out : 2'b00, all_read),
             pack_out(v.e_poped, v.e_empty, 1'b0, v.e_ovf, v.e_unf, v.e_mv, v.e_mo, v.e_ar));
      end

      // Fill to DEPTH: 255 x 01 then a 10 on top.
      for (int i = 0; i < 255; i++) drive(0, 1, 1, 2'b01, 0, 0);
      drive(0, 1, 1, 2'b10, 0, 0);
      chk("full_flag", {14'b0, full, ovf_err}, 16'h0002);
      drive(0, 1, 1, 2'b11, 0, 0);
      chk("overflow", {14'b0, full, ovf_err}, 16'h0003);
      drive(0, 0, 0, 2'b00, 1, 0);
      chk("top_after_ovf", {12'b0, poped, full, ovf_err}, 16'h0009);
      drive(0, 0, 0, 2'b00, 1, 0);
      chk("below_top", {14'b0, poped}, 16'h0001);
      drive(1, 0, 0, 2'b00, 0, 0);
      chk("clear_ovf", {13'b0, is_empty_st, full, ovf_err}, 16'h0004);

      // Async reset in the middle of a replay.
      drive(0, 1, 1, 2'b01, 0, 0);
      drive(0, 1, 1, 2'b10, 0, 0);
      drive(0, 0, 0, 2'b00, 0, 1);
      chk("replay_start", {13'b0, move_valid, move_out}, 16'h0005);
      #2 rst = 1'b0;
      #1;
      chk("async_reset", pack_out(poped, is_empty_st, full, ovf_err, unf_err, move_valid, move_out, all_read),
          pack_out(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      @(negedge clk);
      read = 1'b0;
      rst  = 1'b1;
      drive(0, 0, 0, 2'b00, 0, 0);
      chk("post_reset_idle", {13'b0, move_valid, all_read, is_empty_st}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
